// File: rtl/led_pwm_decoder.sv
// Purpose: measures red/green active-low LED lit-cycle counts per Tick window and decodes the PWM phase.
// Latency: results and Valid/Runt strobes appear one cycle after the closing Tick.
// Backpressure: none; outputs are strobes/registers and cannot be stalled.
module led_pwm_decoder #(
  parameter int CNT_BITS = 10,
  parameter int MIN_WIN  = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Tick,
  input  logic                red,
  input  logic                green,
  output logic [CNT_BITS-1:0] RedCnt,
  output logic [CNT_BITS-1:0] GreenCnt,
  output logic [CNT_BITS-1:0] WinLen,
  output logic [1:0]          Phase,
  output logic                Valid,
  output logic                Runt,
  output logic                Conflict
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] MIN_WIN_C = CNT_BITS'(MIN_WIN);

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] win_cnt, win_nxt;
  logic [CNT_BITS-1:0] red_cnt, red_nxt;
  logic [CNT_BITS-1:0] grn_cnt, grn_nxt;
  logic                close_win;
  logic                accept;
  logic                runt_nxt;
  logic [1:0]          phase_nxt;
  logic                red_lit;
  logic                grn_lit;

  // LED drives are active-low
  assign red_lit = ~red;
  assign grn_lit = ~green;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // FSM state and window counters
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      win_cnt <= '0;
      red_cnt <= '0;
      grn_cnt <= '0;
    end else begin
      state   <= state_nxt;
      win_cnt <= win_nxt;
      red_cnt <= red_nxt;
      grn_cnt <= grn_nxt;
    end
  end

  // Next-state and counter update; a Tick in MEASURE closes the window and
  // preloads the next one with the Tick-cycle sample
  always_comb begin
    state_nxt = state;
    win_nxt   = win_cnt;
    red_nxt   = red_cnt;
    grn_nxt   = grn_cnt;
    close_win = 1'b0;
    case (state)
      IDLE: begin
        if (Tick) begin
          // The opening Tick is the first cycle of the window; LED levels
          // are not sampled while idle, so colour counts start at zero.
          state_nxt = MEASURE;
          win_nxt   = CNT_ONE;
          red_nxt   = '0;
          grn_nxt   = '0;
        end
      end
      MEASURE: begin
        if (Tick) begin
          close_win = 1'b1;
          win_nxt   = CNT_ONE;
          red_nxt   = CNT_BITS'(red_lit);
          grn_nxt   = CNT_BITS'(grn_lit);
        end else begin
          win_nxt = sat_inc(win_cnt);
          if (red_lit) red_nxt = sat_inc(red_cnt);
          if (grn_lit) grn_nxt = sat_inc(grn_cnt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = close_win && (win_cnt >= MIN_WIN_C);
  assign runt_nxt = close_win && !accept;

  // Phase decode against the previous accepted window (held in RedCnt/GreenCnt);
  // equal counts or an all-dark window keep the old phase
  always_comb begin
    phase_nxt = Phase;
    if (red_cnt != '0) begin
      if (red_cnt > RedCnt)      phase_nxt = 2'd0;
      else if (red_cnt < RedCnt) phase_nxt = 2'd1;
    end else if (grn_cnt != '0) begin
      if (grn_cnt > GreenCnt)      phase_nxt = 2'd2;
      else if (grn_cnt < GreenCnt) phase_nxt = 2'd3;
    end
  end

  // Result registers, strobes and sticky conflict flag; runt windows leave
  // results (and therefore the comparison history) untouched
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RedCnt   <= '0;
      GreenCnt <= '0;
      WinLen   <= '0;
      Phase    <= 2'd0;
      Valid    <= 1'b0;
      Runt     <= 1'b0;
      Conflict <= 1'b0;
    end else begin
      Valid <= accept;
      Runt  <= runt_nxt;
      if (accept) begin
        WinLen   <= win_cnt;
        RedCnt   <= red_cnt;
        GreenCnt <= grn_cnt;
        Phase    <= phase_nxt;
      end
      if (state == MEASURE && red_lit && grn_lit) Conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_pwm_decoder.sv
// Purpose: self-checking bench for led_pwm_decoder using a window table plus corner sequences.
// Latency: checks sample outputs 1 time unit after the rising edge that closes each window.
// Backpressure: not applicable; stimulus is free-running.
module tb_led_pwm_decoder;

  localparam int CB = 10;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Tick = 1'b0;
  logic          red = 1'b1;
  logic          green = 1'b1;
  logic [CB-1:0] RedCnt, GreenCnt, WinLen;
  logic [1:0]    Phase;
  logic          Valid, Runt, Conflict;

  int checks = 0;
  int failures = 0;

  led_pwm_decoder #(.CNT_BITS(CB), .MIN_WIN(4)) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .red(red), .green(green),
    .RedCnt(RedCnt), .GreenCnt(GreenCnt), .WinLen(WinLen), .Phase(Phase),
    .Valid(Valid), .Runt(Runt), .Conflict(Conflict)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int len;  int nred; int ngrn;
    int vld;  int runt; int win; int rc; int gc; int ph;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, then sample just after the rising edge
  task automatic cyc(input logic t, input logic r, input logic g);
    Tick = t; red = r; green = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int v, input int rn, input int w,
                         input int rc, input int gc, input int ph);
    chk({tag, "_valid"}, int'(Valid), v);
    chk({tag, "_runt"}, int'(Runt), rn);
    chk({tag, "_winlen"}, int'(WinLen), w);
    chk({tag, "_redcnt"}, int'(RedCnt), rc);
    chk({tag, "_greencnt"}, int'(GreenCnt), gc);
    chk({tag, "_phase"}, int'(Phase), ph);
  endtask

  initial begin
    //          len nred ngrn vld runt win rc gc ph
    vecs[0]  = '{8, 3, 0, 1, 0, 8, 3, 0, 0};
    vecs[1]  = '{8, 5, 0, 1, 0, 8, 5, 0, 0};
    vecs[2]  = '{8, 4, 0, 1, 0, 8, 4, 0, 1};
    vecs[3]  = '{8, 0, 2, 1, 0, 8, 0, 2, 2};
    vecs[4]  = '{8, 0, 1, 1, 0, 8, 0, 1, 3};
    vecs[5]  = '{6, 0, 1, 1, 0, 6, 0, 1, 3};
    vecs[6]  = '{2, 1, 0, 0, 1, 6, 0, 1, 3};
    vecs[7]  = '{4, 2, 0, 1, 0, 4, 2, 0, 0};
    vecs[8]  = '{3, 0, 0, 0, 1, 4, 2, 0, 0};
    vecs[9]  = '{5, 1, 0, 1, 0, 5, 1, 0, 1};
    vecs[10] = '{5, 1, 0, 1, 0, 5, 1, 0, 1};
    vecs[11] = '{4, 0, 0, 1, 0, 4, 0, 0, 1};

    // reset state
    repeat (3) @(posedge Clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_conflict", int'(Conflict), 0);
    Rst = 1'b0;

    // opening Tick from IDLE, then the table of windows
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < vecs[i].len - 1; c++) begin
        cyc(1'b0, (c < vecs[i].nred) ? 1'b0 : 1'b1,
                  (c >= vecs[i].len - 1 - vecs[i].ngrn) ? 1'b0 : 1'b1);
        if (c == 0) begin
          chk($sformatf("vec%0d_strobe_low", i), int'(Valid | Runt), 0);
        end
      end
      cyc(1'b1, 1'b1, 1'b1);
      chk_all($sformatf("vec%0d", i), vecs[i].vld, vecs[i].runt, vecs[i].win,
              vecs[i].rc, vecs[i].gc, vecs[i].ph);
    end
    chk("no_conflict_yet", int'(Conflict), 0);

    // saturation: red held lit for 1100 cycles inside one window
    repeat (1100) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk_all("sat", 1, 0, 1023, 1023, 0, 0);

    // conflict: one cycle with both LEDs lit
    cyc(1'b0, 1'b0, 1'b0);
    chk("conflict_set", int'(Conflict), 1);
    repeat (6) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk_all("conf_win", 1, 0, 8, 1, 1, 1);
    repeat (7) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk_all("dark_win", 1, 0, 8, 0, 0, 1);
    chk("conflict_sticky", int'(Conflict), 1);

    // reset in the middle of a window
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    #2 Rst = 1'b1;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0, 0);
    chk("midrst_conflict", int'(Conflict), 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    // IDLE ignores the LEDs, even both lit
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("idle_conflict", int'(Conflict), 0);
    chk("idle_strobes", int'(Valid | Runt), 0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("first_tick_valid", int'(Valid), 0);
    chk("first_tick_runt", int'(Runt), 0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b1, 1'b1);
    chk("pre_second_tick_valid", int'(Valid), 0);
    cyc(1'b1, 1'b1, 1'b1);
    chk_all("post_rst", 1, 0, 8, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pwm_decoder.md
LED_PWM_DECODER -- requirements
Module: led_pwm_decoder

Interface
REQ-001 Parameter CNT_BITS, default 10: width of the window and lit-cycle counters.
REQ-002 Parameter MIN_WIN, default 4: shortest window, in cycles, that is accepted as valid.
REQ-003 Port Clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 Port Rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port Tick, input, 1: window-boundary strobe, one cycle wide.
REQ-006 Port red, input, 1: red LED drive, active-low (0 = lit).
REQ-007 Port green, input, 1: green LED drive, active-low (0 = lit).
REQ-008 Port RedCnt, output, CNT_BITS: number of red-lit cycles in the last accepted window.
REQ-009 Port GreenCnt, output, CNT_BITS: number of green-lit cycles in the last accepted window.
REQ-010 Port WinLen, output, CNT_BITS: length in cycles of the last accepted window.
REQ-011 Port Phase, output, 2: decoded LED phase (0 red rising, 1 red falling, 2 green rising, 3 green falling).
REQ-012 Port Valid, output, 1: one-cycle strobe; high when RedCnt/GreenCnt/WinLen/Phase update.
REQ-013 Port Runt, output, 1: one-cycle strobe; high when a window is discarded as too short.
REQ-014 Port Conflict, output, 1: sticky flag; set when red and green are sampled lit in the same cycle.

Function
REQ-015 The block SHALL implement an FSM with two states: IDLE and MEASURE.
REQ-016 IDLE SHALL ignore red and green, and SHALL move to MEASURE on Tick with all counters cleared.
REQ-017 MEASURE, on a non-Tick cycle: window counter +1; red==0 -> red counter +1; green==0 -> green counter +1.
REQ-018 All counters SHALL saturate at 2^CNT_BITS-1 and SHALL NOT wrap.
REQ-019 Every Tick in MEASURE SHALL close the window; the Tick cycle itself SHALL be counted in the next window.
REQ-020 Closing a window with window count >= MIN_WIN SHALL register WinLen, RedCnt and GreenCnt, update Phase, and pulse Valid one cycle after the Tick.
REQ-021 Closing a window with window count < MIN_WIN SHALL leave all outputs unchanged, pulse Runt one cycle after the Tick, and SHALL NOT update the previous-count history.
REQ-022 Closing any window SHALL start the next window with its counters preloaded to reflect the Tick-cycle sample: window=1, red=1 if red==0 else 0, green=1 if green==0 else 0.
REQ-023 Phase decode for an accepted window SHALL be:
- new red > 0 and new red > prior red -> 0.
- new red > 0 and new red < prior red -> 1.
- new red == 0, new green > prior green -> 2.
- new red == 0, new green < prior green -> 3.
REQ-024 Phase SHALL hold its value when the relevant counts are equal, or when both new counts are 0.
REQ-025 The prior red and prior green values SHALL be the counts of the previous accepted window, and SHALL be 0 after reset.
REQ-026 Conflict SHALL be set on any MEASURE cycle with red==0 and green==0, and SHALL clear only on Rst.
REQ-027 The FSM SHALL remain in MEASURE after the first Tick; there SHALL be no return to IDLE except through Rst.

Reset
REQ-028 Rst high SHALL set the FSM to IDLE and clear all counters and the history registers.
REQ-029 Rst high SHALL set RedCnt, GreenCnt, WinLen and Phase to 0, and Valid, Runt and Conflict to 0.
REQ-030 Rst asserted mid-window SHALL discard the partial window, with no Valid or Runt strobe.

Verification
REQ-031 Reset, Tick at cycle 0 and cycle 8, red low for 3 cycles, green high -> Valid at cycle 9, WinLen=8, RedCnt=3, GreenCnt=0, Phase=0.
REQ-032 Four successive 8-cycle windows with red-lit counts 3, 5, 4, 0 and green-lit counts 0, 0, 0, 2 -> Phase sequence 0, 0, 1, 2.
REQ-033 Tick, then another Tick 2 cycles later (MIN_WIN=4) -> Runt pulse, no Valid, outputs unchanged from the prior window.
REQ-034 Red held low for 1100 cycles between Ticks (CNT_BITS=10) -> RedCnt=1023, WinLen=1023.
REQ-035 Red and green both low for one cycle -> Conflict=1, and it stays 1 through later windows until Rst.
REQ-036 Rst pulsed during cycle 5 of a window -> all outputs 0, FSM in IDLE, and the next Valid appears only after two further Ticks.
